fetch_queue_frontend: RTL and testbench

- Decoupled, parametrised instruction-fetch front end.
- Generates fetch PCs, issues pipelined word requests to the icache and tracks in-flight requests.
- Buffers returned words with their PC and prediction tag in an FQ_DEPTH-entry queue feeding decode.
- Redirects flush the queue and drop stale in-flight responses; a fetch fault halts fetch until the next redirect.

---
 rtl/fetch_queue_frontend_pkg.sv | 31 +++
 rtl/fetch_queue_frontend_fq_fifo.sv | 72 +++++++
 rtl/fetch_queue_frontend.sv | 140 ++++++++++++++
 tb/tb_fetch_queue_frontend.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_frontend_pkg.sv
// Shared types and sizing for the fetch front end.
// Holds the fetch-queue entry layout, the front-end state encoding and the
// queue / in-flight sizing used by fetch_queue_frontend and fq_fifo.
package tcore_param;

  localparam int unsigned     XLEN            = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR    = 32'h4000_0000;
  localparam int unsigned     FQ_DEPTH        = 4;
  localparam int unsigned     MAX_OUTSTANDING = 2;

  localparam int unsigned FQ_CNT_W  = $clog2(FQ_DEPTH + 1);
  localparam int unsigned OST_CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            pred_taken;
    logic            fault;
  } fq_entry_t;

  typedef enum logic {
    RUN        = 1'b0,
    FAULT_HOLD = 1'b1
  } fe_state_e;

  // Icache requests are always issued on a 4-byte boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_frontend_fq_fifo.sv
// fq_fifo: ring buffer of fq_entry_t with synchronous flush.
// Used both as the instruction queue and as the per-request tag FIFO, so the
// depth need not be a power of two; pointers wrap explicitly.
module fq_fifo
  import tcore_param::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  fq_entry_t                  entry_i,
  output fq_entry_t                  head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH));
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Pointer and occupancy tracking; a flush empties the buffer in one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; the head is only consumed when valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= entry_i;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !flush_i));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o && !flush_i));

endmodule

// File: rtl/fetch_queue_frontend.sv
// fetch_queue_frontend: decoupled instruction-fetch front end.
// Issues pipelined word requests, tracks them in a tag FIFO, buffers returned
// words in the fetch queue and handles redirects and fetch faults.
// Optional macro FQ_BYPASS_EN: an empty queue lets a live response reach the
// inst_* outputs in the same cycle it returns.
module fetch_queue_frontend
  import tcore_param::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  input  logic                pred_taken_i,
  input  logic [XLEN-1:0]     pred_target_i,
  output logic [XLEN-1:0]     fetch_pc_o,
  output logic                ireq_valid_o,
  input  logic                ireq_ready_i,
  output logic [XLEN-1:0]     ireq_addr_o,
  input  logic                ires_valid_i,
  input  logic [31:0]         ires_data_i,
  input  logic                ires_err_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [31:0]         inst_o,
  output logic [XLEN-1:0]     inst_pc_o,
  output logic                inst_pred_taken_o,
  output logic                inst_fault_o,
  output logic [FQ_CNT_W-1:0] fq_count_o
);

  fe_state_e            state_q, state_d;
  logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic [OST_CNT_W-1:0] drop_q, drop_d;
  logic [OST_CNT_W-1:0] outstanding;
  logic                 fetch_en_q;

  logic [FQ_CNT_W-1:0]  fq_count;
  logic                 fq_empty, fq_full;
  logic                 tag_empty, tag_full;
  fq_entry_t            fq_head, tag_head, tag_entry, res_entry, out_entry;

  logic req_fire, res_tracked, res_drop, res_live;
  logic bypass, fq_push, fq_pop;
  logic unused_sigs;

  // Issue only when every in-flight response is guaranteed a queue slot
  assign ireq_valid_o = fetch_en_q && (state_q == RUN) && !redirect_i
                      && (outstanding < OST_CNT_W'(MAX_OUTSTANDING))
                      && ((int'(outstanding) + int'(fq_count)) < int'(FQ_DEPTH));
  assign ireq_addr_o  = ireq_valid_o ? word_align(fetch_pc_q) : '0;
  assign fetch_pc_o   = fetch_pc_q;
  assign req_fire     = ireq_valid_o && ireq_ready_i;

  // Responses with no recorded request (e.g. arriving after a reset) are ignored
  assign res_tracked = ires_valid_i && !tag_empty;
  assign res_drop    = res_tracked && (drop_q != '0);
  assign res_live    = res_tracked && (drop_q == '0) && (state_q == RUN) && !redirect_i;

  assign tag_entry = '{pc: fetch_pc_q, inst: 32'h0, pred_taken: pred_taken_i, fault: 1'b0};
  assign res_entry = '{pc: tag_head.pc, inst: ires_data_i,
                       pred_taken: tag_head.pred_taken, fault: ires_err_i};

`ifdef FQ_BYPASS_EN
  assign bypass = res_live && fq_empty;
`else
  assign bypass = 1'b0;
`endif

  assign fq_push = res_live && !(bypass && inst_ready_i);
  assign fq_pop  = !fq_empty && inst_ready_i;

  assign out_entry         = fq_empty ? res_entry : fq_head;
  assign inst_valid_o      = !fq_empty || bypass;
  assign inst_o            = inst_valid_o ? out_entry.inst : '0;
  assign inst_pc_o         = inst_valid_o ? out_entry.pc : '0;
  assign inst_pred_taken_o = inst_valid_o && out_entry.pred_taken;
  assign inst_fault_o      = inst_valid_o && out_entry.fault;
  assign fq_count_o        = fq_count;

  assign unused_sigs = ^{tag_head.inst, tag_head.fault, fq_full, tag_full};

  // Next fetch PC, stale-response drop count and fault hold/resume decisions
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (res_drop) drop_d = drop_q - OST_CNT_W'(1);
    if (res_live && ires_err_i) state_d = FAULT_HOLD;
    if (req_fire) begin
      fetch_pc_d = pred_taken_i ? pred_target_i : word_align(fetch_pc_q) + XLEN'(4);
    end
    if (redirect_i) begin
      state_d    = RUN;
      fetch_pc_d = redirect_pc_i;
      drop_d     = outstanding - OST_CNT_W'(res_tracked);
    end
  end

  // Front-end state; fetch_en holds off the first request until reset is gone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_VECTOR;
      drop_q     <= '0;
      fetch_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      fetch_en_q <= 1'b1;
    end
  end

  fq_fifo #(.DEPTH(FQ_DEPTH)) u_inst_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (fq_push),
    .pop_i   (fq_pop),
    .entry_i (res_entry),
    .head_o  (fq_head),
    .empty_o (fq_empty),
    .full_o  (fq_full),
    .count_o (fq_count)
  );

  fq_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .pop_i   (res_tracked),
    .entry_i (tag_entry),
    .head_o  (tag_head),
    .empty_o (tag_empty),
    .full_o  (tag_full),
    .count_o (outstanding)
  );

endmodule

// File: tb/tb_fetch_queue_frontend.sv
// Self-checking bench for fetch_queue_frontend: randomized icache/decode/
// predictor traffic against a transaction-level model using epochs for
// redirects and plain queues for in-flight requests and decoded words.
`timescale 1ns/1ps
module tb_fetch_queue_frontend;
  import tcore_param::*;

`ifdef FQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                redirect_i = 1'b0;
  logic [31:0]         redirect_pc_i = '0;
  logic                pred_taken_i = 1'b0;
  logic [31:0]         pred_target_i = '0;
  logic [31:0]         fetch_pc_o;
  logic                ireq_valid_o;
  logic                ireq_ready_i = 1'b0;
  logic [31:0]         ireq_addr_o;
  logic                ires_valid_i = 1'b0;
  logic [31:0]         ires_data_i = '0;
  logic                ires_err_i = 1'b0;
  logic                inst_valid_o;
  logic                inst_ready_i = 1'b0;
  logic [31:0]         inst_o;
  logic [31:0]         inst_pc_o;
  logic                inst_pred_taken_o;
  logic                inst_fault_o;
  logic [FQ_CNT_W-1:0] fq_count_o;

  fetch_queue_frontend dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i), .fetch_pc_o(fetch_pc_o),
    .ireq_valid_o(ireq_valid_o), .ireq_ready_i(ireq_ready_i), .ireq_addr_o(ireq_addr_o),
    .ires_valid_i(ires_valid_i), .ires_data_i(ires_data_i), .ires_err_i(ires_err_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_pred_taken_o(inst_pred_taken_o),
    .inst_fault_o(inst_fault_o), .fq_count_o(fq_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; logic pred; int epoch; } req_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic pred; logic fault; } exp_t;

  req_t        inflight[$];
  exp_t        expq[$];
  logic [31:0] icache_pending[$];
  logic [31:0] model_pc = 32'h4000_0000;
  int          epoch = 0;
  bit          halted = 1'b0;
  bit          model_on = 1'b0;

  int n_compared = 0;
  int n_mismatched = 0;

  int          p_resp = 100, p_ireq_ready = 100, p_ready = 100, p_pred = 0;
  int          p_err_pm = 0, p_redir_pm = 0;
  bit          redir_once = 1'b0;
  logic [31:0] redir_pc = '0;
  bit          force_pred_en = 1'b0;
  logic [31:0] force_pred_pc = '0, force_target = '0;
  bit          force_err_en = 1'b0;
  logic [31:0] force_err_addr = '0;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      if (n_mismatched <= 40)
        $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Monitor + reference model, evaluated mid-cycle while inputs are stable
  req_t mon_req;
  exp_t mon_resp, mon_head;
  bit   mon_have_resp, mon_consumed, mon_exp_ireq, mon_exp_valid;

  always @(negedge clk_i) begin
    if (model_on) begin
      mon_have_resp = 1'b0;
      mon_consumed  = 1'b0;
      mon_exp_ireq  = !halted && !redirect_i && (inflight.size() < int'(MAX_OUTSTANDING))
                      && ((inflight.size() + expq.size()) < int'(FQ_DEPTH));
      checkOutput("ireq_valid", ireq_valid_o, mon_exp_ireq);
      checkOutput("fq_count", fq_count_o, expq.size());
      checkOutput("fetch_pc", fetch_pc_o, model_pc);
      if (ires_valid_i && inflight.size() > 0) begin
        mon_req = inflight.pop_front();
        if (mon_req.epoch == epoch && !halted && !redirect_i) begin
          mon_resp = '{pc: mon_req.pc, inst: mem_word(align_word(mon_req.pc)),
                       pred: mon_req.pred, fault: ires_err_i};
          mon_have_resp = 1'b1;
          if (ires_err_i) halted = 1'b1;
        end
      end
      mon_exp_valid = (expq.size() > 0) || (BYPASS && mon_have_resp);
      checkOutput("inst_valid", inst_valid_o, mon_exp_valid);
      if (mon_exp_valid) begin
        mon_head = (expq.size() > 0) ? expq[0] : mon_resp;
        checkOutput("inst_word", inst_o, mon_head.inst);
        checkOutput("inst_pc", inst_pc_o, mon_head.pc);
        checkOutput("inst_pred", inst_pred_taken_o, mon_head.pred);
        checkOutput("inst_fault", inst_fault_o, mon_head.fault);
        if (inst_valid_o && inst_ready_i) begin
          if (expq.size() > 0) void'(expq.pop_front());
          else mon_consumed = 1'b1;
        end
      end
      if (mon_have_resp && !mon_consumed) expq.push_back(mon_resp);
      if (ireq_valid_o && ireq_ready_i) begin
        checkOutput("ireq_addr", ireq_addr_o, align_word(model_pc));
        inflight.push_back('{pc: model_pc, pred: pred_taken_i, epoch: epoch});
        icache_pending.push_back(ireq_addr_o);
        model_pc = pred_taken_i ? pred_target_i : align_word(model_pc) + 32'd4;
      end
      if (redirect_i) begin
        expq.delete();
        model_pc = redirect_pc_i;
        epoch++;
        halted = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input int cycles);
    logic [31:0] a;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_i);
      #1;
      ires_valid_i = 1'b0;
      ires_err_i   = 1'b0;
      ires_data_i  = '0;
      if (icache_pending.size() > 0 && $urandom_range(99) < p_resp) begin
        a = icache_pending.pop_front();
        ires_valid_i = 1'b1;
        ires_data_i  = mem_word(a);
        ires_err_i   = ($urandom_range(999) < p_err_pm) || (force_err_en && a == force_err_addr);
      end
      ireq_ready_i = ($urandom_range(99) < p_ireq_ready);
      if (force_pred_en && fetch_pc_o == force_pred_pc) begin
        pred_taken_i  = 1'b1;
        pred_target_i = force_target;
      end else begin
        pred_taken_i  = ($urandom_range(99) < p_pred);
        pred_target_i = 32'h4000_0000 + ($urandom_range(255) << 2);
      end
      if (redir_once) begin
        redirect_i    = 1'b1;
        redirect_pc_i = redir_pc;
        redir_once    = 1'b0;
      end else begin
        redirect_i    = ($urandom_range(999) < p_redir_pm);
        redirect_pc_i = 32'h4000_0000 + ($urandom_range(511) << 1);
      end
      inst_ready_i = redirect_i ? 1'b0 : ($urandom_range(99) < p_ready);
    end
  endtask

  task automatic doRedirect(input logic [31:0] pc);
    redir_once = 1'b1;
    redir_pc   = pc;
    applyStimulus(1);
  endtask

  task automatic applyReset(input int cycles);
    @(posedge clk_i);
    #1;
    model_on = 1'b0;
    rst_ni = 1'b0;
    redirect_i = 1'b0; pred_taken_i = 1'b0; ireq_ready_i = 1'b0;
    ires_valid_i = 1'b0; ires_err_i = 1'b0; inst_ready_i = 1'b0;
    icache_pending.delete(); inflight.delete(); expq.delete();
    model_pc = 32'h4000_0000; epoch = 0; halted = 1'b0;
    repeat (cycles) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_inst_valid", inst_valid_o, 1'b0);
    checkOutput("rst_ireq_valid", ireq_valid_o, 1'b0);
    checkOutput("rst_fq_count", fq_count_o, 0);
    checkOutput("rst_inst_word", inst_o, 32'h0);
    checkOutput("rst_inst_pc", inst_pc_o, 32'h0);
    checkOutput("rst_inst_pred", inst_pred_taken_o, 1'b0);
    checkOutput("rst_inst_fault", inst_fault_o, 1'b0);
    checkOutput("rst_ireq_addr", ireq_addr_o, 32'h0);
    checkOutput("rst_fetch_pc", fetch_pc_o, 32'h4000_0000);
    #1;
    rst_ni = 1'b1;
    model_on = 1'b1;
  endtask

  initial begin
    applyReset(3);

    // Streaming with an always-ready decoder and a 1-cycle icache
    applyStimulus(12);

    // Decoder stalls: the queue fills to FQ_DEPTH and issue stops
    p_ready = 0;
    applyStimulus(12);
    checkOutput("stall_fq_full", fq_count_o, FQ_DEPTH);
    p_ready = 100;
    applyStimulus(8);

    // Predicted-taken branch at 0x4000_0004 towards 0x4000_0100
    force_pred_en = 1'b1; force_pred_pc = 32'h4000_0004; force_target = 32'h4000_0100;
    doRedirect(32'h4000_0000);
    applyStimulus(10);
    force_pred_en = 1'b0;

    // Redirect with requests still in flight; stale responses must vanish
    p_resp = 0;
    applyStimulus(4);
    doRedirect(32'h4000_0202);
    p_resp = 100;
    applyStimulus(10);

    // Fault on the word at 0x4000_0008 halts fetch until the next redirect
    force_err_en = 1'b1; force_err_addr = 32'h4000_0008;
    doRedirect(32'h4000_0000);
    applyStimulus(15);
    checkOutput("fault_hold_no_req", ireq_valid_o, 1'b0);
    force_err_en = 1'b0;
    doRedirect(32'h4000_0000);
    applyStimulus(8);

    // Randomized traffic on all interfaces
    p_resp = 60; p_ireq_ready = 75; p_ready = 65; p_pred = 15; p_err_pm = 20; p_redir_pm = 15;
    applyStimulus(3000);

    // Reset mid-transaction, then a late response that must be ignored
    applyReset(2);
    @(posedge clk_i);
    #1;
    ires_valid_i = 1'b1; ires_data_i = 32'hDEAD_BEEF; ireq_ready_i = 1'b0;
    p_resp = 100; p_ireq_ready = 100; p_ready = 100; p_pred = 0; p_err_pm = 0; p_redir_pm = 0;
    applyStimulus(30);

    p_resp = 50; p_ireq_ready = 80; p_ready = 50; p_pred = 20; p_err_pm = 10; p_redir_pm = 20;
    applyStimulus(1500);

    @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
